id_pipe_stage: RTL

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/id_pkg.sv | 48 ++++
 rtl/id_pipe_stage_if.sv | 56 +++++
 rtl/id_regfile.sv | 36 +++
 rtl/id_pipe_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID pipeline stage: opcodes, ALU
// encodings, the control bundle and immediate extraction.
package id_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_MAC   = 7'b1111111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SRL = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101
    } alu_ctrl_t;

    typedef struct packed {
        logic      alusrc;
        logic      memtoreg;
        logic      memread;
        logic      memwrite;
        logic      regwrite;
        logic      mac;
        alu_ctrl_t alu_ctrl;
    } ctrl_t;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B
    } imm_sel_t;

    // 13-bit signed immediate; bit 12 is always instr[31] so callers sign-extend from it.
    function automatic logic [12:0] imm13(input logic [31:0] instr, input imm_sel_t sel);
        case (sel)
            IMM_I:   return {instr[31], instr[31:20]};
            IMM_S:   return {instr[31], instr[31:25], instr[11:7]};
            IMM_B:   return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/id_pipe_stage_if.sv
// Fetch, writeback, hazard and ID/EX signals of the decode stage, bundled
// so the stage and its environment share one connection.
interface id_pipe_stage_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RAW = $clog2(NREG);

    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            wb_we;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            mem_regwrite;
    logic [RAW-1:0]  mem_rd;
    logic            flush;

    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            illegal;

    logic            ex_valid;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_rd_val;
    logic [XLEN-1:0] ex_imm;
    logic [RAW-1:0]  ex_rd;
    logic            ex_alusrc;
    logic            ex_memtoreg;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_regwrite;
    logic            ex_mac;
    logic [2:0]      ex_alu_ctrl;

    modport master (
        output if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data,
               mem_regwrite, mem_rd, flush,
        input  stall, branch_taken, branch_target, illegal,
               ex_valid, ex_rs1_val, ex_rs2_val, ex_rd_val, ex_imm, ex_rd,
               ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite,
               ex_mac, ex_alu_ctrl
    );

    modport slave (
        input  if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data,
               mem_regwrite, mem_rd, flush,
        output stall, branch_taken, branch_target, illegal,
               ex_valid, ex_rs1_val, ex_rs2_val, ex_rd_val, ex_imm, ex_rd,
               ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite,
               ex_mac, ex_alu_ctrl
    );

endinterface

// File: rtl/id_regfile.sv
// Register file: three combinational read ports with write-through bypass,
// one write port; register 0 is hard-wired to zero.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RAW-1:0]  wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    input  logic [RAW-1:0]  ra3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] rd3
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A read of the register being written this cycle sees the new value.
    assign rd1 = (ra1 == '0) ? '0 : (we && wr_addr == ra1) ? wr_data : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (we && wr_addr == ra2) ? wr_data : regs[ra2];
    assign rd3 = (ra3 == '0) ? '0 : (we && wr_addr == ra3) ? wr_data : regs[ra3];

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction decode stage: decode, register read, hazard stall, early
// beq resolution and the ID/EX pipeline register.
module id_pipe_stage
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic           clk,
    input logic           reset,
    id_pipe_stage_if.slave bus
);

    localparam int RAW = $clog2(NREG);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RAW-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val, rd_val;

    ctrl_t           ctrl;
    imm_sel_t        imm_sel;
    logic            legal, use_rs1, use_rs2, use_rd, is_beq;
    logic [12:0]     imm_s13;
    logic [XLEN-1:0] imm_ext;

    logic            ex_hit, load_use, ex_wr_hit, mem_wr_hit, hazard, issue;

    assign opcode = bus.if_instr[6:0];
    assign funct3 = bus.if_instr[14:12];
    assign rs1    = bus.if_instr[15 +: RAW];
    assign rs2    = bus.if_instr[20 +: RAW];
    assign rd     = bus.if_instr[7 +: RAW];

    id_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wb_we),
        .wr_addr (bus.wb_rd),
        .wr_data (bus.wb_data),
        .ra1     (rs1),
        .ra2     (rs2),
        .ra3     (rd),
        .rd1     (rs1_val),
        .rd2     (rs2_val),
        .rd3     (rd_val)
    );

    always_comb begin
        ctrl    = '0;
        imm_sel = IMM_NONE;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        is_beq  = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                ctrl.regwrite = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_ctrl = bus.if_instr[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl.alu_ctrl = ALU_SLL;
                    3'b101:  ctrl.alu_ctrl = ALU_SRL;
                    3'b111:  ctrl.alu_ctrl = ALU_AND;
                    3'b110:  ctrl.alu_ctrl = ALU_OR;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                if (funct3 == 3'b000) begin
                    use_rs1       = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    imm_sel       = IMM_I;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_LOAD: begin
                use_rs1       = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                imm_sel       = IMM_I;
            end
            OP_STORE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                    is_beq        = 1'b1;
                    ctrl.alu_ctrl = ALU_SUB;
                    imm_sel       = IMM_B;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_MAC: begin
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.mac      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl    = '0;
            imm_sel = IMM_NONE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
            is_beq  = 1'b0;
        end
    end

    assign imm_s13 = imm13(bus.if_instr, imm_sel);
    assign imm_ext = {{(XLEN-13){imm_s13[12]}}, imm_s13};

    assign ex_hit   = bus.ex_valid && (bus.ex_rd != '0);
    assign load_use = ex_hit && bus.ex_memread &&
                      ((use_rs1 && bus.ex_rd == rs1) ||
                       (use_rs2 && bus.ex_rd == rs2) ||
                       (use_rd  && bus.ex_rd == rd));
    // beq compares in ID, so any pending producer of its sources must drain first.
    assign ex_wr_hit  = ex_hit && bus.ex_regwrite && (bus.ex_rd == rs1 || bus.ex_rd == rs2);
    assign mem_wr_hit = bus.mem_regwrite && (bus.mem_rd != '0) &&
                        (bus.mem_rd == rs1 || bus.mem_rd == rs2);
    assign hazard     = bus.if_valid && (load_use || (is_beq && (ex_wr_hit || mem_wr_hit)));

    assign bus.stall         = hazard && !bus.flush;
    assign bus.illegal       = bus.if_valid && !legal;
    assign bus.branch_taken  = bus.if_valid && is_beq && !hazard && !bus.flush &&
                               (rs1_val == rs2_val);
    assign bus.branch_target = bus.if_pc + imm_ext;

    assign issue = bus.if_valid && legal && !hazard && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset || !issue) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_rs1_val  <= '0;
            bus.ex_rs2_val  <= '0;
            bus.ex_rd_val   <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_memtoreg <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_mac      <= 1'b0;
            bus.ex_alu_ctrl <= '0;
        end else begin
            bus.ex_valid    <= 1'b1;
            bus.ex_rs1_val  <= rs1_val;
            bus.ex_rs2_val  <= rs2_val;
            bus.ex_rd_val   <= rd_val;
            bus.ex_imm      <= imm_ext;
            bus.ex_rd       <= rd;
            bus.ex_alusrc   <= ctrl.alusrc;
            bus.ex_memtoreg <= ctrl.memtoreg;
            bus.ex_memread  <= ctrl.memread;
            bus.ex_memwrite <= ctrl.memwrite;
            bus.ex_regwrite <= ctrl.regwrite;
            bus.ex_mac      <= ctrl.mac;
            bus.ex_alu_ctrl <= ctrl.alu_ctrl;
        end
    end

endmodule
